tilt_level_indicator: RTL and testbench

//  Converts the raw signed accelerometer axis stream from the SPI master into a smoothed,

---
 rtl/tilt_level_indicator_if.sv | 25 ++
 rtl/tilt_level_indicator.sv | 147 ++++++++++++++
 tb/tb_tilt_level_indicator.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/tilt_level_indicator_if.sv
// rtl/tilt_level_indicator_if.sv - sample input, display mode and level/LED outputs of the tilt indicator
interface tilt_level_indicator_if #(
    parameter int DATA_W   = 15,
    parameter int LEVEL_W  = 4,
    parameter int NUM_LEDS = 15
);
    logic                       sample_valid;
    logic signed [DATA_W-1:0]   sample_data;
    logic                       bar_mode;
    logic [LEVEL_W-1:0]         level;
    logic                       level_strobe;
    logic                       level_changed;
    logic [NUM_LEDS-1:0]        led;
    logic                       stale;

    modport master (
        output sample_valid, sample_data, bar_mode,
        input  level, level_strobe, level_changed, led, stale
    );

    modport slave (
        input  sample_valid, sample_data, bar_mode,
        output level, level_strobe, level_changed, led, stale
    );
endinterface

// File: rtl/tilt_level_indicator.sv
// rtl/tilt_level_indicator.sv - boxcar-filtered, hysteretic tilt level with LED decode and stale detect
module tilt_level_indicator #(
    parameter int DATA_W     = 15,
    parameter int AVG_LOG2   = 2,
    parameter int LEVEL_W    = 4,
    parameter int NUM_LEDS   = 15,
    parameter int IN_MIN     = -256,
    parameter int STEP_SHIFT = 5,
    parameter int HYST       = 4,
    parameter int TIMEOUT    = 400000
) (
    input  logic                  clock,
    input  logic                  reset,
    tilt_level_indicator_if.slave bus
);
    localparam int DEPTH     = 1 << AVG_LOG2;
    localparam int SUM_W     = DATA_W + AVG_LOG2;
    localparam int PTR_W     = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int FILL_W    = AVG_LOG2 + 1;
    localparam int MAX_LEVEL = (1 << LEVEL_W) - 1;
    localparam int CNT_W     = $clog2(TIMEOUT + 1);

    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;

    logic signed [DATA_W-1:0] ring [DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic signed [SUM_W-1:0]  sum;
    logic [FILL_W-1:0]        fill;
    logic                     upd_valid;

    logic [LEVEL_W-1:0]       level_r;
    logic                     primed;
    logic                     strobe_r;
    logic                     changed_r;
    logic [NUM_LEDS-1:0]      led_r;
    logic                     stale_r;
    logic [CNT_W-1:0]         stale_cnt;

    logic signed [31:0]       avg32;
    logic signed [31:0]       d32;
    logic signed [31:0]       q32;
    logic [LEVEL_W-1:0]       cand;
    logic [LEVEL_W-1:0]       level_next;
    logic [CNT_W-1:0]         cnt_next;
    logic                     stale_next;
    logic [NUM_LEDS-1:0]      led_dec;

    function automatic logic signed [31:0] bound(input logic [LEVEL_W-1:0] k);
        return IN_MIN + ($signed(32'(k)) <<< STEP_SHIFT);
    endfunction

    // Stage 0 and 1: capture the sample, then update ring and running sum.
    always_ff @(posedge clock) begin
        if (!reset) begin
            in_valid  <= 1'b0;
            in_data   <= '0;
            wr_ptr    <= '0;
            sum       <= '0;
            fill      <= '0;
            upd_valid <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ring[i] <= '0;
            end
        end else begin
            in_valid  <= bus.sample_valid;
            in_data   <= bus.sample_data;
            upd_valid <= in_valid && (fill >= FILL_W'(DEPTH - 1));
            if (in_valid) begin
                sum          <= sum + SUM_W'(in_data) - SUM_W'(ring[wr_ptr]);
                ring[wr_ptr] <= in_data;
                wr_ptr       <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
                if (fill != FILL_W'(DEPTH)) begin
                    fill <= fill + 1'b1;
                end
            end
        end
    end

    // Quantise the average and apply hysteresis against the present level.
    always_comb begin
        avg32 = 32'(sum) >>> AVG_LOG2;
        d32   = avg32 - IN_MIN;
        q32   = d32 >>> STEP_SHIFT;
        if (d32 < 0) begin
            cand = '0;
        end else if (q32 > MAX_LEVEL) begin
            cand = LEVEL_W'(MAX_LEVEL);
        end else begin
            cand = q32[LEVEL_W-1:0];
        end

        level_next = level_r;
        if (upd_valid) begin
            if (!primed) begin
                level_next = cand;
            end else if ((cand > level_r) && (avg32 >= bound(cand) + HYST)) begin
                level_next = cand;
            end else if ((cand < level_r) && (avg32 < bound(level_r) - HYST)) begin
                level_next = cand;
            end
        end

        if (bus.sample_valid) begin
            cnt_next = '0;
        end else if (stale_cnt == CNT_W'(TIMEOUT)) begin
            cnt_next = stale_cnt;
        end else begin
            cnt_next = stale_cnt + 1'b1;
        end
        stale_next = (cnt_next == CNT_W'(TIMEOUT));

        led_dec = '0;
        for (int k = 1; k <= NUM_LEDS; k++) begin
            led_dec[k-1] = bus.bar_mode ? (32'(level_next) >= k) : (32'(level_next) == k);
        end
    end

    // Stage 2: level, strobes and LEDs; LEDs also track bar_mode and stale every cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            level_r   <= '0;
            primed    <= 1'b0;
            strobe_r  <= 1'b0;
            changed_r <= 1'b0;
            led_r     <= '0;
            stale_r   <= 1'b0;
            stale_cnt <= '0;
        end else begin
            level_r   <= level_next;
            strobe_r  <= upd_valid;
            changed_r <= upd_valid && (level_next != level_r);
            if (upd_valid) begin
                primed <= 1'b1;
            end
            stale_cnt <= cnt_next;
            stale_r   <= stale_next;
            led_r     <= stale_next ? '0 : led_dec;
        end
    end

    assign bus.level         = level_r;
    assign bus.level_strobe  = strobe_r;
    assign bus.level_changed = changed_r;
    assign bus.led           = led_r;
    assign bus.stale         = stale_r;
endmodule

// File: tb/tb_tilt_level_indicator.sv
// tb/tb_tilt_level_indicator.sv - directed and random checks of tilt_level_indicator against a window model
module tb_tilt_level_indicator;
    localparam int DATA_W   = 15;
    localparam int AVG_LOG2 = 2;
    localparam int DEPTH    = 4;
    localparam int LEVEL_W  = 4;
    localparam int NUM_LEDS = 15;
    localparam int IN_MIN   = -256;
    localparam int STEP     = 32;
    localparam int HYST     = 4;
    localparam int TIMEOUT  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tilt_level_indicator_if #(.DATA_W(DATA_W), .LEVEL_W(LEVEL_W), .NUM_LEDS(NUM_LEDS)) bus ();

    tilt_level_indicator #(
        .DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2), .LEVEL_W(LEVEL_W), .NUM_LEDS(NUM_LEDS),
        .IN_MIN(IN_MIN), .STEP_SHIFT(5), .HYST(HYST), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail = 0;

    int win[$];
    int m_future = 0;
    bit m_primed = 0;
    bit dv[2] = '{0, 0};
    int dlev[2] = '{0, 0};
    int m_idle = 0;
    int e_level = 0, e_strobe = 0, e_changed = 0, e_led = 0, e_stale = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int floor_div(input int num, input int den);
        int q;
        q = num / den;
        if ((num % den != 0) && (num < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int led_pattern(input int lev, input bit bm);
        if (bm) return (1 << ((lev > NUM_LEDS) ? NUM_LEDS : lev)) - 1;
        if (lev >= 1 && lev <= NUM_LEDS) return 1 << (lev - 1);
        return 0;
    endfunction

    function automatic int next_level(input int avg, input int cur, input bit primed);
        int c;
        int d;
        d = avg - IN_MIN;
        if (d < 0) c = 0;
        else c = d / STEP;
        if (c > (1 << LEVEL_W) - 1) c = (1 << LEVEL_W) - 1;
        if (!primed) return c;
        if (c > cur && avg >= IN_MIN + c * STEP + HYST) return c;
        if (c < cur && avg < IN_MIN + cur * STEP - HYST) return c;
        return cur;
    endfunction

    task automatic model_edge(input bit r, input bit sv, input int sd, input bit bm);
        int s;
        int nl;
        if (!r) begin
            win.delete();
            m_future = 0; m_primed = 0; dv = '{0, 0}; m_idle = 0;
            e_level = 0; e_strobe = 0; e_changed = 0; e_led = 0; e_stale = 0;
            return;
        end
        e_strobe  = dv[1];
        e_changed = (dv[1] && dlev[1] != e_level) ? 1 : 0;
        if (dv[1]) e_level = dlev[1];
        dv[1] = dv[0]; dlev[1] = dlev[0]; dv[0] = 0;
        if (sv) begin
            win.push_back(sd);
            if (win.size() > DEPTH) void'(win.pop_front());
            if (win.size() == DEPTH) begin
                s = 0;
                foreach (win[i]) s += win[i];
                nl = next_level(floor_div(s, DEPTH), m_future, m_primed);
                m_future = nl; m_primed = 1;
                dv[0] = 1; dlev[0] = nl;
            end
        end
        if (sv) m_idle = 0;
        else if (m_idle < TIMEOUT) m_idle++;
        e_stale = (m_idle == TIMEOUT) ? 1 : 0;
        e_led = e_stale ? 0 : led_pattern(e_level, bm);
    endtask

    task automatic step(input bit r, input bit sv, input int sd, input bit bm);
        rst_n = r;
        bus.sample_valid = sv;
        bus.sample_data = DATA_W'(sd);
        bus.bar_mode = bm;
        model_edge(r, sv, sd, bm);
        @(negedge clk);
        chk("level", 32'(bus.level), e_level);
        chk("level_strobe", 32'(bus.level_strobe), e_strobe);
        chk("level_changed", 32'(bus.level_changed), e_changed);
        chk("led", 32'(bus.led), e_led);
        chk("stale", 32'(bus.stale), e_stale);
    endtask

    task automatic idle(input int n, input bit bm);
        for (int i = 0; i < n; i++) step(1, 0, 0, bm);
    endtask

    initial begin
        bit bm;
        int sd;
        bus.sample_valid = 1'b0;
        bus.sample_data = '0;
        bus.bar_mode = 1'b0;
        @(negedge clk);
        step(0, 0, 0, 0);
        step(0, 1, 100, 0);
        chk("reset_level", 32'(bus.level), 0);
        chk("reset_led", 32'(bus.led), 0);
        chk("reset_stale", 32'(bus.stale), 0);

        // Step input: four zeros, strobe exactly two cycles after the fourth
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
        idle(2, 0);
        chk("warmup_no_strobe", 32'(bus.level_strobe), 0);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        chk("step_t1_no_strobe", 32'(bus.level_strobe), 0);
        step(1, 0, 0, 0);
        chk("step_strobe", 32'(bus.level_strobe), 1);
        chk("step_level", 32'(bus.level), 8);
        chk("step_led", 32'(bus.led), 32'h0080);
        chk("step_changed", 32'(bus.level_changed), 1);

        // Averaging and hysteresis in both directions
        step(1, 1, 128, 0); idle(2, 0);
        chk("avg32_strobe", 32'(bus.level_strobe), 1);
        chk("avg32_changed", 32'(bus.level_changed), 0);
        chk("avg32_level", 32'(bus.level), 8);
        step(1, 1, 16, 0); idle(2, 0);
        chk("avg36_level", 32'(bus.level), 9);
        step(1, 1, -20, 0); idle(2, 0);
        chk("avg31_level", 32'(bus.level), 9);
        step(1, 1, -16, 0); idle(2, 0);
        chk("avg27_level", 32'(bus.level), 8);

        // Saturation and bar mode
        for (int i = 0; i < 4; i++) step(1, 1, -16384, 1);
        idle(2, 1);
        chk("sat_low_level", 32'(bus.level), 0);
        chk("sat_low_led", 32'(bus.led), 0);
        for (int i = 0; i < 4; i++) step(1, 1, 16383, 1);
        idle(2, 1);
        chk("sat_high_level", 32'(bus.level), 15);
        chk("sat_high_led", 32'(bus.led), 32'h7FFF);
        step(1, 0, 0, 0);
        chk("onehot_led", 32'(bus.led), 32'h4000);

        // Stale and recovery
        idle(TIMEOUT + 4, 0);
        chk("stale_set", 32'(bus.stale), 1);
        chk("stale_led", 32'(bus.led), 0);
        step(1, 1, 16383, 0);
        chk("stale_clear", 32'(bus.stale), 0);
        chk("stale_led_restore", 32'(bus.led), 32'h4000);

        // Reset mid-window restarts warm-up
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("midreset_level", 32'(bus.level), 0);
        chk("midreset_led", 32'(bus.led), 0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
        idle(3, 0);
        chk("midreset_no_strobe", 32'(bus.level_strobe), 0);
        step(1, 1, 0, 0); idle(2, 0);
        chk("midreset_strobe", 32'(bus.level_strobe), 1);
        chk("midreset_level8", 32'(bus.level), 8);

        // Randomised traffic
        bm = 0;
        sd = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) bm = ~bm;
            if ($urandom_range(0, 299) == 0) begin
                idle(TIMEOUT + int'($urandom_range(0, 4)) - 2, bm);
            end else if ($urandom_range(0, 499) == 0) begin
                step(0, $urandom_range(0, 1) == 1, sd, bm);
            end else begin
                case ($urandom_range(0, 3))
                    0: sd = int'($urandom_range(0, 32767)) - 16384;
                    1, 2: sd = IN_MIN + STEP * int'($urandom_range(0, 15)) + int'($urandom_range(0, 16)) - 8;
                    default: ;
                endcase
                step(1, $urandom_range(0, 2) != 0, sd, bm);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
